// File: rtl/csa_accum_seq_if.sv
// Job/operand/result bundle for csa_accum_seq: start/abort control, operand
// valid/ready stream and result valid/ready. The master drives jobs and operands.
interface csa_accum_seq_if #(
  parameter int OPW   = 4,
  parameter int ACC_W = 12,
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] num_ops;
  logic             abort;
  logic             in_valid;
  logic [OPW-1:0]   in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             ovf;
  logic             busy;

  modport master (
    output start, num_ops, abort, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, ovf, busy
  );

  modport slave (
    input  start, num_ops, abort, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, ovf, busy
  );
endinterface

// File: rtl/csa_accum_seq.sv
// Carry-save stream accumulator: one 3:2 compression per accepted operand, then a
// single carry-propagate resolve cycle. CSA_ACCUM_SIGNED_EN selects signed operands.
module csa_accum_seq #(
  parameter int OPW   = 4,
  parameter int ACC_W = 12,
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  csa_accum_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_s;
  logic [ACC_W-1:0] r_c;
  logic [CNT_W-1:0] r_rem;
  logic             r_sticky;
  logic [ACC_W-1:0] r_out_sum;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [ACC_W-1:0] w_x;
  logic [ACC_W-1:0] w_maj;
  logic [ACC_W:0]   w_total;
  logic             w_xfer;

`ifdef CSA_ACCUM_SIGNED_EN
  assign w_x = ACC_W'($signed(bus.in_data));
`else
  assign w_x = ACC_W'(bus.in_data);
`endif

  assign w_maj   = (r_s & r_c) | (r_s & w_x) | (r_c & w_x);
  assign w_total = {1'b0, r_s} + {1'b0, r_c};
  assign w_xfer  = bus.in_valid && r_in_ready;

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.ovf       = r_ovf;
  assign bus.busy      = r_busy;

  // NOTE: all state and the handshake outputs are written with <= in this one
  // block; each output is set from the state being entered so it is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_s         <= '0;
      r_c         <= '0;
      r_rem       <= '0;
      r_sticky    <= 1'b0;
      r_out_sum   <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (bus.abort) begin
      // Abort beats transfers and out_ready; the last result stays readable.
      r_state     <= ST_IDLE;
      r_s         <= '0;
      r_c         <= '0;
      r_rem       <= '0;
      r_sticky    <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start && (bus.num_ops != '0)) begin
            r_state    <= ST_ACCUM;
            r_rem      <= bus.num_ops;
            r_s        <= '0;
            r_c        <= '0;
            r_sticky   <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end else if (bus.start) begin
            r_state     <= ST_DONE;
            r_out_sum   <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (w_xfer) begin
            r_s   <= r_s ^ r_c ^ w_x;
            r_c   <= {w_maj[ACC_W-2:0], 1'b0};
            r_rem <= r_rem - CNT_W'(1);
            // A carry shifted past the top bit means the true total exceeds ACC_W.
            if (w_maj[ACC_W-1]) r_sticky <= 1'b1;
            if (r_rem == CNT_W'(1)) begin
              r_state    <= ST_RESOLVE;
              r_in_ready <= 1'b0;
            end
          end
        end
        ST_RESOLVE: begin
          r_out_sum   <= w_total[ACC_W-1:0];
`ifdef CSA_ACCUM_SIGNED_EN
          r_ovf       <= 1'b0;
`else
          r_ovf       <= r_sticky | w_total[ACC_W];
`endif
          r_state     <= ST_DONE;
          r_out_valid <= 1'b1;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
